// File: rtl/keypad_scan4x4_pkg.sv
// Shared keypad definitions: key code width, named keys on the 4x4 layout,
// and helpers for classifying a debounced 16-bit key matrix.
package keypad_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_KEYS = 16;

  typedef logic [KEY_W-1:0]    key_code_t;
  typedef logic [NUM_KEYS-1:0] key_matrix_t;

  // Layout rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D ; code = row*4 + col
  localparam key_code_t KEY_DIGIT_1 = 4'd0;
  localparam key_code_t KEY_DIGIT_2 = 4'd1;
  localparam key_code_t KEY_DIGIT_3 = 4'd2;
  localparam key_code_t KEY_START   = 4'd3;
  localparam key_code_t KEY_DIGIT_4 = 4'd4;
  localparam key_code_t KEY_DIGIT_5 = 4'd5;
  localparam key_code_t KEY_DIGIT_6 = 4'd6;
  localparam key_code_t KEY_PAUSE   = 4'd7;
  localparam key_code_t KEY_DIGIT_7 = 4'd8;
  localparam key_code_t KEY_DIGIT_8 = 4'd9;
  localparam key_code_t KEY_DIGIT_9 = 4'd10;
  localparam key_code_t KEY_MODE    = 4'd11;
  localparam key_code_t KEY_STAR    = 4'd12;
  localparam key_code_t KEY_DIGIT_0 = 4'd13;
  localparam key_code_t KEY_HASH    = 4'd14;
  localparam key_code_t KEY_CLEAR   = 4'd15;

  function automatic logic is_single_key(input key_matrix_t m);
    return (m != '0) && ((m & (m - key_matrix_t'(1))) == '0);
  endfunction

  function automatic key_code_t key_index(input key_matrix_t m);
    key_code_t idx;
    idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (m[k]) idx = key_code_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan4x4_if.sv
// Keypad matrix lines plus the decoded key outputs seen by the control FSM.
interface keypad_scan4x4_if;

  logic [3:0]           row_in;
  logic [3:0]           col_out;
  keypad_pkg::key_code_t key_code;
  logic                 key_valid;
  logic                 key_held;

  modport slave (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport master (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/keypad_scan4x4_tick_div.sv
// Free-running divider: one-cycle tick every DIV clocks, counter wraps to 0.
module tick_div #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 keypad scanner: walks an active-low column, builds a 16-bit snapshot per
// scan, debounces whole snapshots and reports single-key presses.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scan4x4_if.slave   kp
);

  localparam int SCW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SCW-1:0] STABLE_MAX = SCW'(DEBOUNCE_SCANS);

  logic            tick;
  logic [3:0]      row_sync1, row_sync2;
  logic [3:0]      rows_pressed;
  logic [1:0]      col;
  key_matrix_t     snap, snap_full, prev_snap, deb_state;
  logic [SCW-1:0]  stable_cnt, stable_next;
  logic            scan_done, deb_load;

  tick_div #(.DIV(SCAN_DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rows_pressed = ~row_sync2;
  assign scan_done    = tick && (col == 2'd3);

  // Snapshot including the column being sampled on this tick.
  always_comb begin
    snap_full = snap;
    for (int r = 0; r < 4; r++) begin
      snap_full[{2'(r), col}] = rows_pressed[r];
    end
  end

  always_comb begin
    stable_next = 1;
    if (snap_full == prev_snap) begin
      stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
    end
  end

  assign deb_load = scan_done && (stable_next == STABLE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_sync1    <= 4'b1111;
      row_sync2    <= 4'b1111;
      col          <= 2'd0;
      kp.col_out   <= 4'b1110;
      snap         <= '0;
      prev_snap    <= '0;
      stable_cnt   <= '0;
      deb_state    <= '0;
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      row_sync1    <= kp.row_in;
      row_sync2    <= row_sync1;
      kp.col_out   <= ~(4'b0001 << col);
      kp.key_valid <= 1'b0;

      if (tick) begin
        snap <= snap_full;
        col  <= col + 2'd1;
      end

      if (scan_done) begin
        prev_snap  <= snap_full;
        stable_cnt <= stable_next;
      end

      // Multi-key snapshots clear key_held but never touch key_code.
      if (deb_load) begin
        deb_state   <= snap_full;
        kp.key_held <= is_single_key(snap_full);
        if (is_single_key(snap_full) && (snap_full != deb_state)) begin
          kp.key_code  <= key_index(snap_full);
          kp.key_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Directed + randomized bench for keypad_scan4x4 against a scan-level
// debounce model (SCAN_DIV=4, DEBOUNCE_SCANS=3, 16 cycles per scan).
module tb_keypad_scan4x4;
  import keypad_pkg::*;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pressed;

  always #5 clk = ~clk;

  keypad_scan4x4_if kp ();

  keypad_scan4x4 #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp.slave)
  );

  // Physical keypad: a row is pulled low when a pressed key sits on the driven column.
  always_comb begin
    kp.row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kp.col_out[c]) kp.row_in[r] = 1'b0;
      end
    end
  end

  logic [15:0] hist[$];
  logic [15:0] m_deb;
  logic [3:0]  m_code;
  logic        m_held, m_valid;
  int          n_pass, n_checks;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    m_deb   = '0;
    m_code  = '0;
    m_held  = 1'b0;
    m_valid = 1'b0;
  endtask

  // Debounced state follows the matrix once the last DB whole scans agree.
  task automatic model_scan(input logic [15:0] s);
    bit all_eq;
    hist.push_back(s);
    if (hist.size() > DB) void'(hist.pop_front());
    m_valid = 1'b0;
    if (hist.size() == DB) begin
      all_eq = 1'b1;
      foreach (hist[i]) if (hist[i] != s) all_eq = 1'b0;
      if (all_eq) begin
        if ($countones(s) == 1 && s != m_deb) begin
          m_valid = 1'b1;
          for (int k = 0; k < 16; k++) if (s[k]) m_code = 4'(k);
        end
        m_held = ($countones(s) == 1);
        m_deb  = s;
      end
    end
  endtask

  // Entered at the falling edge of a scan's first cycle; returns at the next one.
  task automatic scan_step(input logic [15:0] mask, input bit first);
    bit         col_ok;
    int         extra;
    logic [3:0] exp_col;
    check("key_valid", kp.key_valid, m_valid);
    check("key_code", kp.key_code, m_code);
    check("key_held", kp.key_held, m_held);
    col_ok  = (kp.col_out === (first ? 4'b1110 : 4'b0111));
    pressed = mask;
    extra   = 0;
    for (int j = 1; j < SCAN; j++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((j - 1) / SD));
      if (kp.col_out !== exp_col) col_ok = 1'b0;
      if (kp.key_valid !== 1'b0) extra++;
    end
    check("col_out_seq", col_ok, 1);
    check("valid_extra", extra, 0);
    @(negedge clk);
    model_scan(mask);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_col_out", kp.col_out, 4'b1110);
    check("rst_key_valid", kp.key_valid, 0);
    check("rst_key_code", kp.key_code, 0);
    check("rst_key_held", kp.key_held, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev_mask, mask;
    int          kind, hold, a, b;
    n_pass   = 0;
    n_checks = 0;
    rst      = 1'b1;
    pressed  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    scan_step(16'h0, 1'b1);
    repeat (12) scan_step(16'h0, 1'b0);

    // Row 2 / col 1 -> code 9, then release.
    repeat (5) scan_step(16'h1 << 9, 1'b0);
    repeat (4) scan_step(16'h0, 1'b0);

    // Bounce: toggle every scan, then hold steady.
    for (int i = 0; i < 5; i++) scan_step((i % 2 == 0) ? (16'h1 << 9) : 16'h0, 1'b0);
    repeat (4) scan_step(16'h1 << 9, 1'b0);
    repeat (4) scan_step(16'h0, 1'b0);

    // Two keys: no report; dropping one reports the remaining key 0.
    repeat (4) scan_step((16'h1 << 0) | (16'h1 << 5), 1'b0);
    repeat (4) scan_step(16'h1 << 0, 1'b0);
    repeat (4) scan_step(16'h0, 1'b0);

    // Rollover without release.
    repeat (4) scan_step(16'h1 << KEY_START, 1'b0);
    repeat (4) scan_step(16'h1 << KEY_STAR, 1'b0);
    repeat (4) scan_step(16'h0, 1'b0);

    // Reset partway through the second debounce scan of a press.
    repeat (2) scan_step(16'h1 << KEY_PAUSE, 1'b0);
    repeat (7) @(negedge clk);
    do_reset();
    scan_step(16'h1 << KEY_PAUSE, 1'b1);
    repeat (4) scan_step(16'h1 << KEY_PAUSE, 1'b0);

    // Randomized presses, releases, multi-presses and short bounces.
    prev_mask = 16'h1 << KEY_PAUSE;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       mask = 16'h0;
        1, 2:    mask = 16'h1 << $urandom_range(0, 15);
        3: begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          mask = (16'h1 << a) | (16'h1 << b);
        end
        4:       mask = prev_mask;
        default: begin
          a = $urandom_range(0, 2);
          mask = 16'h1 << ((a == 0) ? KEY_START : (a == 1) ? KEY_PAUSE : KEY_MODE);
        end
      endcase
      hold = $urandom_range(1, 4);
      repeat (hold) scan_step(mask, 1'b0);
      prev_mask = mask;
    end
    scan_step(16'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
